// File: rtl/inv_sub_bytes_iter.sv
`default_nettype none
// ============================================================================
// Module      : inv_sub_bytes_iter (with helper inv_sub_bytes_iter_sbox)
// Description : Iterative AES InvSubBytes engine. A 128-bit state is latched
//               on an input handshake, then LANES bytes per clock are passed
//               through LANES shared S-box lanes. Bytes are processed MSB
//               byte first. The finished state is presented on DataOut with
//               a valid/ready handshake.
// Parameters  : LANES - bytes substituted per cycle (1,2,4,8,16);
//               N = 16/LANES iteration cycles per block.
// Ports       : Clk      in   1    clock, rising edge
//               Rst_n    in   1    synchronous reset, active-low
//               InValid  in   1    DataIn holds a valid state
//               InReady  out  1    engine accepts DataIn this cycle
//               DataIn   in   128  input state, byte k = DataIn[127-8k -: 8]
//               EncMode  in   1    (only with INV_SUB_BYTES_ENC_MODE_EN)
//                                  1 = forward S-box, 0 = inverse S-box
//               OutValid out  1    DataOut holds a finished state
//               OutReady in   1    consumer accepts DataOut this cycle
//               DataOut  out  128  substituted state, same byte order
//               Busy     out  1    high while substituting
// Macro       : INV_SUB_BYTES_ENC_MODE_EN adds EncMode and the forward S-box.
// Revision    : 1.0 - initial release
// ============================================================================

// Pure combinational byte substitution lane.
module inv_sub_bytes_iter_sbox (
`ifdef INV_SUB_BYTES_ENC_MODE_EN
  input  logic       enc,
`endif
  input  logic [7:0] a,
  output logic [7:0] d
);
  // Table entry for byte value v sits at bits [8*(255-v) +: 8].
  localparam logic [2047:0] c_inv_sbox = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

`ifdef INV_SUB_BYTES_ENC_MODE_EN
  localparam logic [2047:0] c_fwd_sbox = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign d = enc ? c_fwd_sbox[8*(255-int'(a)) +: 8]
                 : c_inv_sbox[8*(255-int'(a)) +: 8];
`else
  assign d = c_inv_sbox[8*(255-int'(a)) +: 8];
`endif
endmodule

module inv_sub_bytes_iter #(
  parameter int LANES = 4
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         InValid,
  output logic         InReady,
  input  logic [127:0] DataIn,
`ifdef INV_SUB_BYTES_ENC_MODE_EN
  input  logic         EncMode,
`endif
  output logic         OutValid,
  input  logic         OutReady,
  output logic [127:0] DataOut,
  output logic         Busy
);
  localparam int c_n  = 16 / LANES;
  localparam int c_cw = (c_n > 1) ? $clog2(c_n) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [127:0]    r_data;
  logic [127:0]    r_dout;
  logic [127:0]    w_sub;
  logic [c_cw-1:0] r_cnt;
  logic            w_last;
  logic            w_accept;
  logic [7:0]      w_lane_in  [LANES];
  logic [7:0]      w_lane_out [LANES];
`ifdef INV_SUB_BYTES_ENC_MODE_EN
  logic            r_enc;
`endif

  assign w_last   = (r_cnt == c_cw'(c_n - 1));
  assign w_accept = InValid & InReady;
  assign DataOut  = r_dout;

  // Lane l handles byte counter*LANES + l of the current slice.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_lane_in[l] = r_data[127 - 8*(int'(r_cnt)*LANES + l) -: 8];

    inv_sub_bytes_iter_sbox u_sbox (
`ifdef INV_SUB_BYTES_ENC_MODE_EN
      .enc (r_enc),
`endif
      .a   (w_lane_in[l]),
      .d   (w_lane_out[l])
    );
  end

  // Slice substituted in place; bytes outside the slice pass through.
  always_comb begin
    w_sub = r_data;
    for (int l = 0; l < LANES; l++) begin
      w_sub[127 - 8*(int'(r_cnt)*LANES + l) -: 8] = w_lane_out[l];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    InReady     = 1'b0;
    OutValid    = 1'b0;
    Busy        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        InReady = 1'b1;
        if (InValid) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        Busy = 1'b1;
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        OutValid = 1'b1;
        // A new block may only enter on the same edge the result is popped.
        InReady  = OutReady;
        if (OutReady) w_state_nxt = InValid ? ST_RUN : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_state <= ST_IDLE;
      r_data  <= '0;
      r_dout  <= '0;
      r_cnt   <= '0;
`ifdef INV_SUB_BYTES_ENC_MODE_EN
      r_enc   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_data <= DataIn;
        r_cnt  <= '0;
`ifdef INV_SUB_BYTES_ENC_MODE_EN
        r_enc  <= EncMode;
`endif
      end else if (r_state == ST_RUN) begin
        r_data <= w_sub;
        if (w_last) begin
          r_cnt  <= '0;
          // Output register updates only when a block completes.
          r_dout <= w_sub;
        end else begin
          r_cnt  <= r_cnt + 1'b1;
        end
      end
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_inv_sub_bytes_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_inv_sub_bytes_iter
// Description : Directed bench for inv_sub_bytes_iter. Three engines with
//               LANES = 4, 1 and 16 share clock and reset; each has its own
//               handshake and data signals (index 0, 1, 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inv_sub_bytes_iter;
  logic         Clk = 1'b0;
  logic         rst_n;
  logic         iv   [3];
  logic         ir   [3];
  logic         ov   [3];
  logic         ordy [3];
  logic         busy [3];
  logic [127:0] din  [3];
  logic [127:0] dout [3];
`ifdef INV_SUB_BYTES_ENC_MODE_EN
  logic         enc  [3];
  logic         enc_req;
`endif

  int lat_exp [3] = '{4, 16, 1};
  int n_vec = 0;
  int n_err = 0;

  localparam logic [127:0] c_fips_in  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] c_fips_out = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] c_all63    = {16{8'h63}};
  localparam logic [127:0] c_all16    = {16{8'h16}};
  localparam logic [127:0] c_all00    = {16{8'h00}};
  localparam logic [127:0] c_allff    = {16{8'hff}};

  always #5 Clk = ~Clk;

  inv_sub_bytes_iter #(.LANES(4)) u_l4 (
    .Clk(Clk), .Rst_n(rst_n), .InValid(iv[0]), .InReady(ir[0]), .DataIn(din[0]),
`ifdef INV_SUB_BYTES_ENC_MODE_EN
    .EncMode(enc[0]),
`endif
    .OutValid(ov[0]), .OutReady(ordy[0]), .DataOut(dout[0]), .Busy(busy[0])
  );

  inv_sub_bytes_iter #(.LANES(1)) u_l1 (
    .Clk(Clk), .Rst_n(rst_n), .InValid(iv[1]), .InReady(ir[1]), .DataIn(din[1]),
`ifdef INV_SUB_BYTES_ENC_MODE_EN
    .EncMode(enc[1]),
`endif
    .OutValid(ov[1]), .OutReady(ordy[1]), .DataOut(dout[1]), .Busy(busy[1])
  );

  inv_sub_bytes_iter #(.LANES(16)) u_l16 (
    .Clk(Clk), .Rst_n(rst_n), .InValid(iv[2]), .InReady(ir[2]), .DataIn(din[2]),
`ifdef INV_SUB_BYTES_ENC_MODE_EN
    .EncMode(enc[2]),
`endif
    .OutValid(ov[2]), .OutReady(ordy[2]), .DataOut(dout[2]), .Busy(busy[2])
  );

  // One block through engine sel with OutReady held high.
  task automatic run_block(input int sel, input logic [127:0] d,
                           input logic [127:0] exp, input string tag);
    int lat;
    @(negedge Clk);
    din[sel] = d; iv[sel] = 1'b1; ordy[sel] = 1'b1;
`ifdef INV_SUB_BYTES_ENC_MODE_EN
    enc[sel] = enc_req;
`endif
    #1;
    n_vec++;
    if (ir[sel] !== 1'b1) begin
      n_err++; $display("FAIL %s inready: got %b want 1", tag, ir[sel]);
    end
    @(negedge Clk);
    iv[sel] = 1'b0; din[sel] = '0;
`ifdef INV_SUB_BYTES_ENC_MODE_EN
    enc[sel] = ~enc_req;
`endif
    n_vec++;
    if (busy[sel] !== 1'b1) begin
      n_err++; $display("FAIL %s busy: got %b want 1", tag, busy[sel]);
    end
    lat = 0;
    while (ov[sel] !== 1'b1 && lat < 40) begin
      @(negedge Clk); lat++;
    end
    n_vec++;
    if (lat != lat_exp[sel]) begin
      n_err++; $display("FAIL %s latency: got %0d want %0d", tag, lat, lat_exp[sel]);
    end
    n_vec++;
    if (dout[sel] !== exp) begin
      n_err++; $display("FAIL %s dataout: got %h want %h", tag, dout[sel], exp);
    end
    @(negedge Clk);
    n_vec++;
    if (ov[sel] !== 1'b0) begin
      n_err++; $display("FAIL %s pop: outvalid got %b want 0", tag, ov[sel]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b1; din[i] = '0;
`ifdef INV_SUB_BYTES_ENC_MODE_EN
      enc[i] = 1'b0;
`endif
    end
    repeat (2) @(negedge Clk);
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (ir[i] !== 1'b1) begin n_err++; $display("FAIL reset%0d inready: got %b want 1", i, ir[i]); end
      n_vec++;
      if (ov[i] !== 1'b0) begin n_err++; $display("FAIL reset%0d outvalid: got %b want 0", i, ov[i]); end
      n_vec++;
      if (busy[i] !== 1'b0) begin n_err++; $display("FAIL reset%0d busy: got %b want 0", i, busy[i]); end
      n_vec++;
      if (dout[i] !== '0) begin n_err++; $display("FAIL reset%0d dataout: got %h want 0", i, dout[i]); end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fips();
    run_block(0, c_fips_in, c_fips_out, "fips_l4");
  endtask

  task automatic test_patterns();
    for (int s = 0; s < 3; s++) begin
      run_block(s, c_all63, c_all00, "all63");
      run_block(s, c_all16, c_allff, "all16");
    end
    run_block(1, c_fips_in, c_fips_out, "fips_l1");
    run_block(2, c_fips_in, c_fips_out, "fips_l16");
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge Clk);
    din[0] = c_fips_in; iv[0] = 1'b1; ordy[0] = 1'b0;
    @(negedge Clk);
    iv[0] = 1'b0; din[0] = '0;
    lat = 0;
    while (ov[0] !== 1'b1 && lat < 40) begin
      @(negedge Clk); lat++;
    end
    n_vec++;
    if (lat != 4) begin n_err++; $display("FAIL bp latency: got %0d want 4", lat); end
    for (int i = 0; i < 10; i++) begin
      n_vec++;
      if (ov[0] !== 1'b1) begin n_err++; $display("FAIL bp hold outvalid: got %b want 1", ov[0]); end
      n_vec++;
      if (dout[0] !== c_fips_out) begin n_err++; $display("FAIL bp hold dataout: got %h want %h", dout[0], c_fips_out); end
      n_vec++;
      if (ir[0] !== 1'b0) begin n_err++; $display("FAIL bp hold inready: got %b want 0", ir[0]); end
      @(negedge Clk);
    end
    ordy[0] = 1'b1; iv[0] = 1'b1; din[0] = c_all16;
    #1;
    n_vec++;
    if (ir[0] !== 1'b1) begin n_err++; $display("FAIL b2b inready: got %b want 1", ir[0]); end
    @(negedge Clk);
    iv[0] = 1'b0; din[0] = '0;
    n_vec++;
    if (ov[0] !== 1'b0) begin n_err++; $display("FAIL b2b popped: outvalid got %b want 0", ov[0]); end
    n_vec++;
    if (busy[0] !== 1'b1) begin n_err++; $display("FAIL b2b busy: got %b want 1", busy[0]); end
    lat = 0;
    while (ov[0] !== 1'b1 && lat < 40) begin
      @(negedge Clk); lat++;
    end
    n_vec++;
    if (lat != 4) begin n_err++; $display("FAIL b2b latency: got %0d want 4", lat); end
    n_vec++;
    if (dout[0] !== c_allff) begin n_err++; $display("FAIL b2b dataout: got %h want %h", dout[0], c_allff); end
    @(negedge Clk);
  endtask

  task automatic test_reset_mid_run();
    @(negedge Clk);
    din[0] = c_all63; iv[0] = 1'b1; ordy[0] = 1'b1;
    @(negedge Clk);
    iv[0] = 1'b0; din[0] = '0;
    repeat (2) @(negedge Clk);
    rst_n = 1'b0;
    @(negedge Clk);
    rst_n = 1'b1;
    n_vec++;
    if (ir[0] !== 1'b1) begin n_err++; $display("FAIL midrst inready: got %b want 1", ir[0]); end
    n_vec++;
    if (busy[0] !== 1'b0) begin n_err++; $display("FAIL midrst busy: got %b want 0", busy[0]); end
    n_vec++;
    if (dout[0] !== '0) begin n_err++; $display("FAIL midrst dataout: got %h want 0", dout[0]); end
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if (ov[0] !== 1'b0) begin n_err++; $display("FAIL midrst outvalid: got %b want 0", ov[0]); end
      @(negedge Clk);
    end
    run_block(0, c_fips_in, c_fips_out, "after_rst");
  endtask

`ifdef INV_SUB_BYTES_ENC_MODE_EN
  task automatic test_enc_mode();
    enc_req = 1'b1;
    run_block(0, c_fips_out, c_fips_in, "enc_fwd_l4");
    run_block(1, c_fips_out, c_fips_in, "enc_fwd_l1");
    enc_req = 1'b0;
    run_block(0, c_fips_in, c_fips_out, "enc_inv_l4");
    run_block(2, c_fips_in, c_fips_out, "enc_inv_l16");
  endtask
`endif

  initial begin
`ifdef INV_SUB_BYTES_ENC_MODE_EN
    enc_req = 1'b0;
`endif
    test_reset();
    test_fips();
    test_patterns();
    test_back_to_back();
    test_reset_mid_run();
`ifdef INV_SUB_BYTES_ENC_MODE_EN
    test_enc_mode();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

`default_nettype wire
